rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one Mux datapath among CHANNELS requesters.
- Drives the Mux `sel` and `enable` inputs directly from registered state, so the Mux output always reflects exactly one granted requester or zero.
- Optional burst limit forces release so that no requester starves the others.
- Sits between the requesting agents and the shared Mux, in the same clock domain as the agents.

Parameters:
- CHANNELS, 4, number of requesters; must be >= 2.
- MAX_BURST, 4, maximum consecutive granted cycles per grant; 0 = unlimited.
- ADDR_SIZE, $clog2(CHANNELS), width of `sel`; derived, not overridden.
- CNT_SIZE, $clog2(MAX_BURST+1) (minimum 1), burst counter width; derived.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  CHANNELS  request per channel; level-sensitive; held for as long as access is wanted.
- grant  output  CHANNELS  one-hot grant, or all zeros; registered.
- sel  output  ADDR_SIZE  index of the granted channel; connects to Mux `sel`.
- enable  output  1  high while any grant is active; connects to Mux `enable`.
- burst_cnt  output  CNT_SIZE  number of cycles the current grant has been held, minus 1; 0 when idle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - grant=0, sel=0, enable=0, burst_cnt=0, state=IDLE.
  - Priority pointer last=CHANNELS-1, so channel 0 has highest priority first.
- Every output is a flop output; none is combinational from `req`.
- Priority: search order is last+1, last+2, ... with wrap modulo CHANNELS. The first asserted req in that order wins.
- IDLE:
  - If any req is high at an edge: the winner is granted on that edge (grant appears 1 cycle after req is sampled); state -> GRANT; burst_cnt=0; last=winner.
  - If no req is high: remain in IDLE with all outputs 0.
- GRANT, owner o, evaluated at each edge:
  - Normal release (req[o]=0): if another req is pending, the next winner is granted on the same edge with no bubble, last=winner, burst_cnt=0. Otherwise state -> IDLE, grant=0, enable=0, burst_cnt=0.
  - Forced release (MAX_BURST!=0, burst_cnt==MAX_BURST-1, req[o]=1): re-arbitrate. Because last=o, o has lowest priority. If another req is pending it wins. If only o requests, o is re-granted and burst_cnt returns to 0.
  - Hold (neither release condition): grant, sel and enable are unchanged; burst_cnt increments. With MAX_BURST=0 the counter saturates at its maximum value.
- Invariants:
  - sel == index of the set bit of grant whenever enable=1.
  - sel holds its last value when enable=0 (the Mux output is then zero).
  - grant has at most one bit set in every cycle.
  - enable == |grant.
- Simultaneous events:
  - Multiple reqs rising on the same edge: resolved by the pointer order.
  - A req rising on the same edge as an owner release is included in that arbitration.
- Reset asserted mid-grant: outputs clear immediately. After reset deasserts, arbitration restarts from the pointer reset value.
- MAX_BURST=1: the grant rotates every cycle among active requesters.

Test Plan (CHANNELS=4, MAX_BURST=4 unless stated):
- Reset release, req=0001 at cycle 0 -> grant=0001, sel=0, enable=1 at cycle 1; burst_cnt runs 0,1,2,3; at cycle 5 channel 0 is re-granted (sole requester) with burst_cnt=0.
- req=1111 held continuously -> grant sequence is 0001, 0010, 0100, 1000, 0001, with each grant lasting exactly 4 cycles and no idle cycles between grants.
- Owner 2 drops req while req=1001 is pending (last=2) -> next cycle grant=1000, sel=3, burst_cnt=0, with no enable gap.
- Sole owner drops req -> next cycle grant=0000, enable=0, sel keeps its previous value, burst_cnt=0; a new req=0100 two cycles later gives grant=0100 one cycle after it.
- reset pulsed mid-grant of channel 3 (asynchronous, between edges) -> grant=0, enable=0 with no clock edge required; with req=1111 after release, grant=0001 first.
- MAX_BURST=0, req=0010 held 20 cycles while req=0001 is also asserted -> grant stays 0010 throughout; burst_cnt saturates at 1 (CNT_SIZE=1); after req[1] drops, grant=0001.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving a shared Mux sel/enable, with optional burst limit
module rr_mux_arbiter #(
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 4,
  localparam int ADDR_SIZE = $clog2(CHANNELS),
  localparam int CNT_SIZE  = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  req,
  output logic [CHANNELS-1:0]  grant,
  output logic [ADDR_SIZE-1:0] sel,
  output logic                 enable,
  output logic [CNT_SIZE-1:0]  burst_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state;
  logic [ADDR_SIZE-1:0] last;
  logic [ADDR_SIZE-1:0] win;
  logic                 found;
  logic                 forced;
  logic                 hold;
  int                   k;
  // search starts just after the last winner, so the current owner is always tried last
  always_comb begin
    win = '0;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      k = (int'(last) + i) % CHANNELS;
      if (!found && req[k]) begin
        found = 1'b1;
        win = ADDR_SIZE'(k);
      end
    end
  end
  assign forced = (MAX_BURST != 0) && (burst_cnt == CNT_SIZE'(MAX_BURST - 1));
  assign hold   = (state == BUSY) && req[last] && !forced;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      enable    <= 1'b0;
      burst_cnt <= '0;
      last      <= ADDR_SIZE'(CHANNELS - 1);
    end else if (hold) begin
      burst_cnt <= (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
    end else if (found) begin
      state     <= BUSY;
      grant     <= CHANNELS'(1) << win;
      sel       <= win;
      enable    <= 1'b1;
      burst_cnt <= '0;
      last      <= win;
    end else begin
      state     <= IDLE;
      grant     <= '0;
      enable    <= 1'b0;
      burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of round-robin order, burst limit, release and async reset
module tb_rr_mux_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req_b;
  logic [3:0] grant, grant_b;
  logic [1:0] sel, sel_b;
  logic       enable, enable_b;
  logic [2:0] burst_cnt;
  logic [0:0] burst_cnt_b;
  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.CHANNELS(4), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .sel(sel), .enable(enable), .burst_cnt(burst_cnt)
  );
  rr_mux_arbiter #(.CHANNELS(4), .MAX_BURST(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(grant_b),
    .sel(sel_b), .enable(enable_b), .burst_cnt(burst_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    req_b = 4'b0000;
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_cnt", 32'(burst_cnt), 0);
    // sole requester: burst of 4 then re-granted
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_sel", 32'(sel), 0);
      chk("t1_enable", 32'(enable), 1);
      chk("t1_cnt", 32'(burst_cnt), 32'(j));
    end
    @(negedge clk);
    chk("t1_regrant", 32'(grant), 32'h1);
    chk("t1_regrant_cnt", 32'(burst_cnt), 0);
    // all requesting: rotation with 4-cycle grants, no gaps
    req = 4'b1111;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk("t2_grant0", 32'(grant), 32'h1);
      chk("t2_cnt0", 32'(burst_cnt), 32'(j));
    end
    for (int c = 1; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk("t2_grant", 32'(grant), 32'h1 << c);
        chk("t2_sel", 32'(sel), 32'(c));
        chk("t2_enable", 32'(enable), 1);
        chk("t2_cnt", 32'(burst_cnt), 32'(j));
      end
    end
    @(negedge clk);
    chk("t2_wrap", 32'(grant), 32'h1);
    chk("t2_wrap_cnt", 32'(burst_cnt), 0);
    // owner 0 drops, channel 2 wins; then owner 2 drops with 1001 pending
    req = 4'b0100;
    @(negedge clk);
    chk("t3_grant2", 32'(grant), 32'h4);
    chk("t3_sel2", 32'(sel), 2);
    req = 4'b1001;
    @(negedge clk);
    chk("t3_grant3", 32'(grant), 32'h8);
    chk("t3_sel3", 32'(sel), 3);
    chk("t3_cnt", 32'(burst_cnt), 0);
    chk("t3_enable", 32'(enable), 1);
    // sole owner drops: idle, sel holds
    req = 4'b0000;
    @(negedge clk);
    chk("t4_grant", 32'(grant), 0);
    chk("t4_enable", 32'(enable), 0);
    chk("t4_sel_hold", 32'(sel), 3);
    chk("t4_cnt", 32'(burst_cnt), 0);
    @(negedge clk);
    chk("t4_idle", 32'(grant), 0);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_new_grant", 32'(grant), 32'h4);
    chk("t4_new_sel", 32'(sel), 2);
    chk("t4_new_enable", 32'(enable), 1);
    // async reset mid-grant of channel 3
    req = 4'b1000;
    @(negedge clk);
    chk("t5_pre_grant", 32'(grant), 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_grant", 32'(grant), 0);
    chk("t5_async_enable", 32'(enable), 0);
    chk("t5_async_sel", 32'(sel), 0);
    chk("t5_async_cnt", 32'(burst_cnt), 0);
    #1 reset = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("t5_restart", 32'(grant), 32'h1);
    req = 4'b0000;
    // unlimited burst: channel 1 keeps the grant, counter saturates at 1
    req_b = 4'b0010;
    @(negedge clk);
    chk("t6_grant", 32'(grant_b), 32'h2);
    chk("t6_cnt0", 32'(burst_cnt_b), 0);
    req_b = 4'b0011;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("t6_hold_grant", 32'(grant_b), 32'h2);
      chk("t6_sat_cnt", 32'(burst_cnt_b), 1);
    end
    req_b = 4'b0001;
    @(negedge clk);
    chk("t6_handoff", 32'(grant_b), 32'h1);
    chk("t6_handoff_sel", 32'(sel_b), 0);
    chk("t6_handoff_cnt", 32'(burst_cnt_b), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
